// File: rtl/div_unit.sv
// Iterative RV64M divide/remainder unit (restoring radix-2, one quotient bit per cycle).
// Covers DIV/DIVU/REM/REMU and their W variants. The unit holds upstream via div_o_busy
// while it computes, then presents the result with a one-cycle div_o_valid strobe.
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_i_start,
    input  logic [3:0]      div_i_div_info,
    input  logic [3:0]      div_i_rem_info,
    input  logic [XLEN-1:0] div_i_src1,
    input  logic [XLEN-1:0] div_i_src2,
    input  logic [4:0]      div_i_rd,
    input  logic            div_i_flush,
    output logic            div_o_busy,
    output logic            div_o_valid,
    output logic [XLEN-1:0] div_o_result,
    output logic [4:0]      div_o_rd,
    output logic            div_o_reg_wen
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    // Sign-extends a W result from bit 31.
    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            is_rem_q, is_rem_d;
    logic            is_w_q, is_w_d;
    logic [4:0]      rd_pend_q, rd_pend_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            op_any, op_signed, op_w, op_rem, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
    logic            a_neg, b_neg, div_zero, overflow, special;
    logic [XLEN-1:0] sp_raw, sp_res;
    logic [XLEN:0]   shifted, diff;
    logic            bit_ge;
    logic [XLEN-1:0] rem_next, quot_next, fin_q, fin_r, fin_raw, fin_res;

    // Decode the request one-hots with fixed priority div > divu > divw > divuw > rem > ... > remuw.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        op_signed = 1'b0;
        op_w      = 1'b0;
        op_rem    = 1'b0;
        op_any    = |{div_i_div_info, div_i_rem_info};
        if (div_i_div_info[3]) begin
            op_signed = 1'b1;
        end else if (div_i_div_info[2]) begin
            op_signed = 1'b0;
        end else if (div_i_div_info[1]) begin
            op_signed = 1'b1;
            op_w      = 1'b1;
        end else if (div_i_div_info[0]) begin
            op_w      = 1'b1;
        end else if (div_i_rem_info[3]) begin
            op_rem    = 1'b1;
            op_signed = 1'b1;
        end else if (div_i_rem_info[2]) begin
            op_rem    = 1'b1;
        end else if (div_i_rem_info[1]) begin
            op_rem    = 1'b1;
            op_signed = 1'b1;
            op_w      = 1'b1;
        end else if (div_i_rem_info[0]) begin
            op_rem    = 1'b1;
            op_w      = 1'b1;
        end
    end

    // Prepare operands (W narrowing, magnitudes) and detect the two shortcut cases.
    always_comb begin
        a_ext = div_i_src1;
        b_ext = div_i_src2;
        if (op_w) begin
            a_ext = op_signed ? sext_w(div_i_src1) : {{(XLEN-32){1'b0}}, div_i_src1[31:0]};
            b_ext = op_signed ? sext_w(div_i_src2) : {{(XLEN-32){1'b0}}, div_i_src2[31:0]};
        end
        a_neg    = op_signed & a_ext[XLEN-1];
        b_neg    = op_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_val  = op_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        overflow = op_signed && (a_ext == min_val) && (b_ext == '1);
        special  = div_zero | overflow;
        if (div_zero) begin
            sp_raw = op_rem ? a_ext : '1;
        end else begin
            sp_raw = op_rem ? '0 : a_ext;
        end
        sp_res = op_w ? sext_w(sp_raw) : sp_raw;
        accept = div_i_start && op_any && (state_q != S_CALC) && !div_i_flush;
    end

    // One restoring step plus sign fix-up of the final quotient/remainder.
    always_comb begin
        shifted   = {rem_q, quot_q[XLEN-1]};
        diff      = shifted - {1'b0, divisor_q};
        bit_ge    = ~diff[XLEN];
        rem_next  = bit_ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quot_next = {quot_q[XLEN-2:0], bit_ge};
        fin_q     = neg_q_q ? -quot_next : quot_next;
        fin_r     = neg_r_q ? -rem_next : rem_next;
        fin_raw   = is_rem_q ? fin_r : fin_q;
        fin_res   = is_w_q ? sext_w(fin_raw) : fin_raw;
    end

    // Next-state and datapath register update; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        is_rem_d  = is_rem_q;
        is_w_d    = is_w_q;
        rd_pend_d = rd_pend_q;
        rd_d      = rd_q;
        result_d  = result_q;
        if (div_i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_CALC: begin
                    rem_d  = rem_next;
                    quot_d = quot_next;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        result_d = fin_res;
                        rd_d     = rd_pend_q;
                        state_d  = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        rd_pend_d = div_i_rd;
                        if (special) begin
                            result_d = sp_res;
                            rd_d     = div_i_rd;
                            state_d  = S_DONE;
                        end else begin
                            // W dividends sit in the upper half so 32 steps consume them.
                            rem_d     = '0;
                            quot_d    = op_w ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
                            divisor_d = b_mag;
                            neg_q_d   = a_neg ^ b_neg;
                            neg_r_d   = a_neg;
                            is_rem_d  = op_rem;
                            is_w_d    = op_w;
                            cnt_d     = op_w ? CW'(31) : CW'(XLEN-1);
                            state_d   = S_CALC;
                        end
                    end
                end
            endcase
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            is_rem_q  <= 1'b0;
            is_w_q    <= 1'b0;
            rd_pend_q <= '0;
            rd_q      <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            is_rem_q  <= is_rem_d;
            is_w_q    <= is_w_d;
            rd_pend_q <= rd_pend_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
        end
    end

    assign div_o_busy    = (state_q == S_CALC);
    assign div_o_valid   = (state_q == S_DONE);
    assign div_o_result  = result_q;
    assign div_o_rd      = rd_q;
    assign div_o_reg_wen = div_o_valid && (rd_q != '0);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, randomized operations against an
// arithmetic reference model, priority decode, flush, back-to-back and async reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [3:0]  div_info;
    logic [3:0]  rem_info;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [4:0]  rd;
    logic        busy;
    logic        valid;
    logic [63:0] result;
    logic [4:0]  rd_o;
    logic        reg_wen;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_unit #(.XLEN(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_i_start   (start),
        .div_i_div_info(div_info),
        .div_i_rem_info(rem_info),
        .div_i_src1    (src1),
        .div_i_src2    (src2),
        .div_i_rd      (rd),
        .div_i_flush   (flush),
        .div_o_busy    (busy),
        .div_o_valid   (valid),
        .div_o_result  (result),
        .div_o_rd      (rd_o),
        .div_o_reg_wen (reg_wen)
    );

    // op: 0 div, 1 divu, 2 divw, 3 divuw, 4 rem, 5 remu, 6 remw, 7 remuw
    function automatic logic [63:0] model(input int op, input logic [63:0] a, input logic [63:0] b);
        bit          is_rem = (op >= 4);
        bit          is_w   = ((op % 4) >= 2);
        bit          sg     = ((op % 2) == 0);
        logic [31:0] a32 = a[31:0];
        logic [31:0] b32 = b[31:0];
        logic [31:0] r32;
        logic [63:0] r64;
        int          sa;
        int          sb;
        longint      la;
        longint      lb;
        if (is_w) begin
            sa = int'(a32);
            sb = int'(b32);
            if (b32 == 32'd0)                                   r32 = is_rem ? a32 : 32'hFFFF_FFFF;
            else if (sg && a32 == 32'h8000_0000 && b32 == '1)   r32 = is_rem ? 32'd0 : a32;
            else if (sg)                                        r32 = is_rem ? 32'(sa % sb) : 32'(sa / sb);
            else                                                r32 = is_rem ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        la = longint'(a);
        lb = longint'(b);
        if (b == 64'd0)                                          r64 = is_rem ? a : '1;
        else if (sg && a == 64'h8000_0000_0000_0000 && b == '1)  r64 = is_rem ? 64'd0 : a;
        else if (sg)                                             r64 = is_rem ? 64'(la % lb) : 64'(la / lb);
        else                                                     r64 = is_rem ? a % b : a / b;
        return r64;
    endfunction

    function automatic int exp_latency(input int op, input logic [63:0] a, input logic [63:0] b);
        bit is_w = ((op % 4) >= 2);
        bit sg   = ((op % 2) == 0);
        if (is_w) begin
            if (b[31:0] == 32'd0 || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 1;
            return 33;
        end
        if (b == 64'd0 || (sg && a == 64'h8000_0000_0000_0000 && b == '1)) return 1;
        return 65;
    endfunction

    // Drives one request at a negedge; returns at the negedge of cycle E+1.
    task automatic issue(input logic [7:0] vec, input logic [63:0] a, input logic [63:0] b, input logic [4:0] r);
        {div_info, rem_info} = vec;
        src1  = a;
        src2  = b;
        rd    = r;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        div_info = '0;
        rem_info = '0;
    endtask

    // Counts cycles from E+1 until valid; stays at the negedge of the valid cycle.
    task automatic wait_result(output int lat, output int busy_cycles, output bit got);
        lat = 0;
        busy_cycles = 0;
        got = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (valid === 1'b1) begin
                lat = k;
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (result !== 64'd0)  begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (rd_o !== 5'd0)     begin errors++; $display("FAIL reset_rd: got %0d expected 0", rd_o); end
        checks++; if (reg_wen !== 1'b0)  begin errors++; $display("FAIL reset_wen: got %b expected 0", reg_wen); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int          op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
    } dcase_t;

    task automatic test_directed();
        dcase_t cs[9];
        int lat, bc;
        bit got;
        cs = '{
            '{0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65},
            '{4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65},
            '{1, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1},
            '{5, 64'd100, 64'd0, 64'd100, 1},
            '{0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1},
            '{4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1},
            '{3, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33},
            '{6, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33},
            '{3, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33}
        };
        foreach (cs[i]) begin
            issue(8'h80 >> cs[i].op, cs[i].a, cs[i].b, 5'd5);
            wait_result(lat, bc, got);
            checks++; if (!got || lat != cs[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, cs[i].lat); end
            checks++; if (result !== cs[i].res)    begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, result, cs[i].res); end
            checks++; if (bc != cs[i].lat - 1)     begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, cs[i].lat - 1); end
            checks++; if (rd_o !== 5'd5 || reg_wen !== 1'b1) begin errors++; $display("FAIL dir%0d_rd_wen: got rd=%0d wen=%b expected rd=5 wen=1", i, rd_o, reg_wen); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int op, lat, bc, el;
        bit got;
        logic [63:0] a, b, er;
        logic [4:0] r;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 7);
            case ($urandom_range(0, 5))
                0:       a = 64'h8000_0000_0000_0000;
                1:       a = 64'hFFFF_FFFF_8000_0000;
                2:       a = 64'h0000_0000_8000_0000;
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 7))
                0:       b = 64'd0;
                1:       b = '1;
                2, 3:    b = 64'($urandom_range(1, 100));
                4:       b = {$urandom, 32'd0};
                5:       b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            r  = 5'($urandom_range(1, 31));
            er = model(op, a, b);
            el = exp_latency(op, a, b);
            issue(8'h80 >> op, a, b, r);
            wait_result(lat, bc, got);
            checks++; if (!got || lat != el) begin errors++; $display("FAIL rand%0d_latency op=%0d: got %0d expected %0d", n, op, lat, el); end
            checks++; if (result !== er || rd_o !== r) begin errors++; $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h rd=%0d expected %h rd=%0d", n, op, a, b, result, rd_o, er, r); end
            @(negedge clk);
        end
    endtask

    task automatic test_priority();
        logic [7:0] vecs[4];
        logic [63:0] a, b, er;
        int op, lat, bc;
        bit got;
        vecs = '{8'b0110_0000, 8'b0001_1000, 8'b0000_0011, 8'b1111_1111};
        foreach (vecs[i]) begin
            op = -1;
            for (int j = 0; j < 8; j++) if (op < 0 && vecs[i][7-j]) op = j;
            a  = {$urandom, $urandom};
            b  = {$urandom, 32'($urandom_range(3, 1000))};
            er = model(op, a, b);
            issue(vecs[i], a, b, 5'd11);
            wait_result(lat, bc, got);
            checks++; if (!got || result !== er) begin errors++; $display("FAIL prio%0d: got %h expected %h (op %0d)", i, result, er, op); end
            @(negedge clk);
        end
        // No op bits set: start must be ignored.
        issue(8'h00, 64'd5, 64'd1, 5'd3);
        wait_result(lat, bc, got);
        checks++; if (got || bc != 0) begin errors++; $display("FAIL prio_none_ignored: got valid=%b busy_cycles=%0d expected none", got, bc); end
    endtask

    task automatic test_rd_zero();
        int lat, bc;
        bit got;
        issue(8'h40, 64'd1000, 64'd7, 5'd0);
        wait_result(lat, bc, got);
        checks++; if (!got || reg_wen !== 1'b0 || rd_o !== 5'd0) begin errors++; $display("FAIL rd_zero: got valid=%b wen=%b rd=%0d expected valid=1 wen=0 rd=0", got, reg_wen, rd_o); end
        checks++; if (result !== 64'd142) begin errors++; $display("FAIL rd_zero_result: got %h expected %h", result, 64'd142); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int lat, bc;
        bit got;
        issue(8'h80, 64'd1000, 64'd10, 5'd7);
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got busy=%b valid=%b expected 0 0", busy, valid); end
        @(negedge clk);
        issue(8'h40, 64'd1000, 64'd10, 5'd9);
        wait_result(lat, bc, got);
        checks++; if (!got || lat != 65) begin errors++; $display("FAIL flush_next_latency: got %0d expected 65", lat); end
        checks++; if (result !== 64'd100 || rd_o !== 5'd9) begin errors++; $display("FAIL flush_next_result: got %h rd=%0d expected %h rd=9", result, rd_o, 64'd100); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bc, seen;
        bit got;
        logic [63:0] a1, a2, b2;
        a1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom};
        b2 = 64'($urandom_range(2, 50000));
        issue(8'h80, a1, 64'd3, 5'd1);
        wait_result(lat, bc, got);
        checks++; if (!got || result !== model(0, a1, 64'd3)) begin errors++; $display("FAIL b2b_first: got %h expected %h", result, model(0, a1, 64'd3)); end
        issue(8'h80, a2, b2, 5'd2);
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_pulse_width: got valid=%b busy=%b expected 0 1", valid, busy); end
        wait_result(lat, bc, got);
        checks++; if (!got || lat != 65 || result !== model(0, a2, b2)) begin errors++; $display("FAIL b2b_second: got lat=%0d %h expected lat=65 %h", lat, result, model(0, a2, b2)); end
        @(negedge clk);
        // Flush in the DONE cycle keeps the pulse but blocks a simultaneous start.
        issue(8'h40, 64'd77, 64'd0, 5'd4);
        wait_result(lat, bc, got);
        checks++; if (!got || lat != 1) begin errors++; $display("FAIL done_flush_pulse: got lat=%0d expected 1", lat); end
        flush = 1'b1;
        issue(8'h80, 64'd1000, 64'd10, 5'd6);
        flush = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_flush_block: got valid=%b busy=%b expected 0 0", valid, busy); end
        seen = 0;
        repeat (70) begin @(negedge clk); if (valid === 1'b1) seen++; end
        checks++; if (seen != 0 || result !== 64'hFFFF_FFFF_FFFF_FFFF || rd_o !== 5'd4) begin errors++; $display("FAIL done_flush_hold: got pulses=%0d result=%h rd=%0d expected 0 all-ones 4", seen, result, rd_o); end
    endtask

    task automatic test_async_reset();
        int seen;
        issue(8'h80, 64'd123456, 64'd7, 5'd8);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL arst_ctrl: got busy=%b valid=%b expected 0 0", busy, valid); end
        checks++; if (result !== 64'd0 || rd_o !== 5'd0) begin errors++; $display("FAIL arst_data: got result=%h rd=%0d expected 0 0", result, rd_o); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (80) begin @(negedge clk); if (valid === 1'b1 || busy === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL arst_no_pulse: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        div_info = '0;
        rem_info = '0;
        src1     = '0;
        src2     = '0;
        rd       = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_priority();
        test_rd_zero();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
